// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcodes, immediate formats and ID-stage output record
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } imm_fmt_e;

    typedef enum logic {
        SQ_RUN,
        SQ_SQUASH
    } sq_state_e;

    // Everything the IF/ID latch presents downstream, kept as one record
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [12:0] label;
        logic        branch;
        logic        jump;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic        illegal;
    } id_out_t;

    function automatic id_out_t make_bubble(input logic [31:0] nop);
        id_out_t b;
        b      = '0;
        b.insn = nop;
        return b;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extraction and sign extension
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] insn,
    input  imm_fmt_e    format,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (format)
            FMT_I:   imm = {{20{insn[31]}}, insn[31:20]};
            FMT_S:   imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            FMT_B:   imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            FMT_U:   imm = {insn[31:12], 12'b0};
            FMT_J:   imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - IF/ID latch and RV32I decode with jump-shadow squash
module id_stage
    import rv32_pkg::*;
#(
    parameter int          JUMP_PENALTY = 1,
    parameter logic [31:0] NOP_INSN     = rv32_pkg::NOP_INSN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] insn,
    input  logic [31:0] pc_in,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] insn_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
    output logic [12:0] label,
    output logic        branch,
    output logic        jump,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src,
    output logic        illegal
);

    localparam logic [1:0] PENALTY   = 2'(JUMP_PENALTY);
    localparam bit         SQUASH_EN = (JUMP_PENALTY > 0);

    sq_state_e  state, state_nxt;
    logic [1:0] sq_cnt, sq_cnt_nxt;
    id_out_t    out_q, out_nxt, cap, bubble;

    imm_fmt_e    fmt;
    logic [31:0] dec_imm;
    logic        d_branch, d_jump, d_mem_read, d_mem_write;
    logic        d_reg_write, d_alu_src, d_illegal;

    imm_gen u_imm_gen (
        .insn   (insn),
        .format (fmt),
        .imm    (dec_imm)
    );

    always_comb begin
        fmt         = FMT_R;
        d_branch    = 1'b0;
        d_jump      = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_alu_src   = 1'b0;
        d_illegal   = 1'b0;
        case (insn[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt         = FMT_U;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OPC_JAL: begin
                fmt         = FMT_J;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
            end
            OPC_JALR: begin
                fmt         = FMT_I;
                d_jump      = 1'b1;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                fmt      = FMT_B;
                d_branch = 1'b1;
            end
            OPC_LOAD: begin
                fmt         = FMT_I;
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OPC_STORE: begin
                fmt         = FMT_S;
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt         = FMT_I;
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            OPC_OP: begin
                fmt         = FMT_R;
                d_reg_write = 1'b1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // Record loaded on a normal capture; writes to x0 are dropped here
    always_comb begin
        cap           = '0;
        cap.valid     = 1'b1;
        cap.insn      = insn;
        cap.pc        = pc_in;
        cap.rd        = insn[11:7];
        cap.rs1       = insn[19:15];
        cap.rs2       = insn[24:20];
        cap.funct3    = insn[14:12];
        cap.funct7    = insn[31:25];
        cap.imm       = dec_imm;
        cap.label     = d_branch ? dec_imm[12:0] : 13'd0;
        cap.branch    = d_branch;
        cap.jump      = d_jump;
        cap.mem_read  = d_mem_read;
        cap.mem_write = d_mem_write;
        cap.reg_write = d_reg_write && (insn[11:7] != 5'd0);
        cap.alu_src   = d_alu_src;
        cap.illegal   = d_illegal;
        bubble        = make_bubble(NOP_INSN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SQ_RUN;
            sq_cnt <= 2'd0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sq_cnt_nxt = sq_cnt;
        if (flush) begin
            state_nxt  = SQ_RUN;
            sq_cnt_nxt = 2'd0;
        end else if (stall) begin
            state_nxt  = state;
            sq_cnt_nxt = sq_cnt;
        end else if (state == SQ_SQUASH) begin
            sq_cnt_nxt = sq_cnt - 2'd1;
            if (sq_cnt_nxt == 2'd0) begin
                state_nxt = SQ_RUN;
            end
        end else if (SQUASH_EN && in_valid && d_jump) begin
            state_nxt  = SQ_SQUASH;
            sq_cnt_nxt = PENALTY;
        end
    end

    always_comb begin
        out_nxt = out_q;
        if (flush) begin
            out_nxt = bubble;
        end else if (stall) begin
            out_nxt = out_q;
        end else if (state == SQ_SQUASH || !in_valid) begin
            out_nxt = bubble;
        end else begin
            out_nxt = cap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= bubble;
        end else begin
            out_q <= out_nxt;
        end
    end

    assign out_valid = out_q.valid;
    assign insn_out  = out_q.insn;
    assign pc_out    = out_q.pc;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign funct3    = out_q.funct3;
    assign funct7    = out_q.funct7;
    assign imm       = out_q.imm;
    assign label     = out_q.label;
    assign branch    = out_q.branch;
    assign jump      = out_q.jump;
    assign mem_read  = out_q.mem_read;
    assign mem_write = out_q.mem_write;
    assign reg_write = out_q.reg_write;
    assign alu_src   = out_q.alu_src;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [31:0] insn, pc_in;

    logic        out_valid, branch, jump, mem_read, mem_write, reg_write, alu_src, illegal;
    logic [31:0] insn_out, pc_out, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] label;

    logic        b_out_valid, b_branch, b_jump, b_mem_read, b_mem_write, b_reg_write, b_alu_src, b_illegal;
    logic [31:0] b_insn_out, b_pc_out, b_imm;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3;
    logic [6:0]  b_funct7;
    logic [12:0] b_label;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.JUMP_PENALTY(1)) dut (
        .clk(clk), .rst(rst), .insn(insn), .pc_in(pc_in), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_valid(out_valid), .insn_out(insn_out),
        .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .label(label), .branch(branch), .jump(jump), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src), .illegal(illegal)
    );

    id_stage #(.JUMP_PENALTY(3)) dut3 (
        .clk(clk), .rst(rst), .insn(insn), .pc_in(pc_in), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out_valid(b_out_valid), .insn_out(b_insn_out),
        .pc_out(b_pc_out), .rd(b_rd), .rs1(b_rs1), .rs2(b_rs2), .funct3(b_funct3), .funct7(b_funct7),
        .imm(b_imm), .label(b_label), .branch(b_branch), .jump(b_jump), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .reg_write(b_reg_write), .alu_src(b_alu_src), .illegal(b_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        insn = 32'h00500093; pc_in = 32'h10; in_valid = 1'b1;
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", out_valid); end
        checks++; if (insn_out !== 32'h13) begin errors++; $display("FAIL rst_insn got %h exp 00000013", insn_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_out); end
        checks++; if (imm !== 32'h0) begin errors++; $display("FAIL rst_imm got %h exp 0", imm); end
        checks++; if ({reg_write, alu_src, mem_read, mem_write, branch, jump, illegal} !== 7'b0)
            begin errors++; $display("FAIL rst_ctrl got %b exp 0", {reg_write, alu_src, mem_read, mem_write, branch, jump, illegal}); end
        checks++; if (rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d exp 0", rd); end
        rst = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rel_valid got %h exp 1", out_valid); end
    endtask

    task automatic test_op_imm();
        insn = 32'h00500093; pc_in = 32'h10; in_valid = 1'b1;
        tick();
        checks++; if (imm !== 32'd5) begin errors++; $display("FAIL addi_imm got %h exp 5", imm); end
        checks++; if (rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d exp 1", rd); end
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL addi_rw got %h exp 1", reg_write); end
        checks++; if (alu_src !== 1'b1) begin errors++; $display("FAIL addi_alusrc got %h exp 1", alu_src); end
        checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL addi_pc got %h exp 10", pc_out); end
        checks++; if (insn_out !== 32'h00500093) begin errors++; $display("FAIL addi_insn got %h exp 00500093", insn_out); end
    endtask

    task automatic test_branch_load();
        insn = 32'h0C000263; pc_in = 32'h14;
        tick();
        checks++; if (branch !== 1'b1) begin errors++; $display("FAIL beq_branch got %h exp 1", branch); end
        checks++; if (label !== 13'd196) begin errors++; $display("FAIL beq_label got %0d exp 196", label); end
        checks++; if (imm !== 32'd196) begin errors++; $display("FAIL beq_imm got %h exp c4", imm); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL beq_rw got %h exp 0", reg_write); end
        insn = 32'h0040A103; pc_in = 32'h18;
        tick();
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL lw_memrd got %h exp 1", mem_read); end
        checks++; if (rd !== 5'd2 || rs1 !== 5'd1) begin errors++; $display("FAIL lw_regs got rd=%0d rs1=%0d exp rd=2 rs1=1", rd, rs1); end
        checks++; if (imm !== 32'd4) begin errors++; $display("FAIL lw_imm got %h exp 4", imm); end
        checks++; if (label !== 13'd0 || branch !== 1'b0) begin errors++; $display("FAIL lw_label got %0d/%h exp 0/0", label, branch); end
    endtask

    task automatic test_store_lui();
        insn = 32'hFE20AE23; pc_in = 32'h1C;
        tick();
        checks++; if (imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL sw_imm got %h exp fffffffc", imm); end
        checks++; if (mem_write !== 1'b1 || reg_write !== 1'b0) begin errors++; $display("FAIL sw_ctrl got mw=%h rw=%h exp 1/0", mem_write, reg_write); end
        checks++; if (rs2 !== 5'd2 || funct3 !== 3'd2) begin errors++; $display("FAIL sw_fields got rs2=%0d f3=%0d exp 2/2", rs2, funct3); end
        insn = 32'h123452B7; pc_in = 32'h20;
        tick();
        checks++; if (imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm got %h exp 12345000", imm); end
        checks++; if (rd !== 5'd5 || reg_write !== 1'b1) begin errors++; $display("FAIL lui_rd got rd=%0d rw=%h exp 5/1", rd, reg_write); end
    endtask

    task automatic test_jump_squash();
        insn = 32'h008000EF; pc_in = 32'h20; in_valid = 1'b1;
        tick();
        checks++; if (jump !== 1'b1 || imm !== 32'd8) begin errors++; $display("FAIL jal_out got jump=%h imm=%h exp 1/8", jump, imm); end
        checks++; if (out_valid !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("FAIL jal_valid got v=%h rw=%h exp 1/1", out_valid, reg_write); end
        insn = 32'h00500093; pc_in = 32'h24;
        tick();
        checks++; if (out_valid !== 1'b0 || jump !== 1'b0) begin errors++; $display("FAIL squash_bubble got v=%h j=%h exp 0/0", out_valid, jump); end
        checks++; if (insn_out !== 32'h13) begin errors++; $display("FAIL squash_insn got %h exp 00000013", insn_out); end
        pc_in = 32'h28;
        tick();
        checks++; if (out_valid !== 1'b1 || pc_out !== 32'h28) begin errors++; $display("FAIL post_squash got v=%h pc=%h exp 1/28", out_valid, pc_out); end
    endtask

    task automatic test_stall_flush();
        insn = 32'h00500093; pc_in = 32'h30; in_valid = 1'b1;
        tick();
        stall = 1'b1; insn = 32'h0040A103; pc_in = 32'h34;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'h30 || insn_out !== 32'h00500093 || out_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold%0d got pc=%h insn=%h exp 30/00500093", i, pc_out, insn_out); end
        end
        flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || insn_out !== 32'h13) begin errors++; $display("FAIL stall_flush got v=%h insn=%h exp 0/13", out_valid, insn_out); end
        stall = 1'b0; flush = 1'b0;
        insn = 32'h008000EF; pc_in = 32'h38;
        tick();
        stall = 1'b1; insn = 32'h00500093; pc_in = 32'h3C;
        tick(); tick();
        checks++; if (jump !== 1'b1 || pc_out !== 32'h38) begin errors++; $display("FAIL stall_jal got j=%h pc=%h exp 1/38", jump, pc_out); end
        stall = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_squash got %h exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || pc_out !== 32'h3C) begin errors++; $display("FAIL stall_resume got v=%h pc=%h exp 1/3c", out_valid, pc_out); end
    endtask

    task automatic test_long_squash();
        rst = 1'b1; tick(); rst = 1'b0;
        insn = 32'h008000EF; pc_in = 32'h40; in_valid = 1'b1;
        tick();
        checks++; if (b_jump !== 1'b1) begin errors++; $display("FAIL p3_jal got %h exp 1", b_jump); end
        insn = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h44 + 32'(4 * i);
            tick();
            checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL p3_squash%0d got %h exp 0", i, b_out_valid); end
        end
        pc_in = 32'h50;
        tick();
        checks++; if (b_out_valid !== 1'b1 || b_pc_out !== 32'h50) begin errors++; $display("FAIL p3_resume got v=%h pc=%h exp 1/50", b_out_valid, b_pc_out); end
        // flush partway through a 3-slot squash must clear the counter
        insn = 32'h008000EF; pc_in = 32'h60;
        tick();
        insn = 32'h00500093; pc_in = 32'h64;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; pc_in = 32'h6C;
        tick();
        checks++; if (b_out_valid !== 1'b1 || b_pc_out !== 32'h6C) begin errors++; $display("FAIL flush_squash got v=%h pc=%h exp 1/6c", b_out_valid, b_pc_out); end
        insn = 32'h008000EF; pc_in = 32'h70;
        tick();
        rst = 1'b1; insn = 32'h00500093;
        tick();
        rst = 1'b0; pc_in = 32'h78;
        tick();
        checks++; if (b_out_valid !== 1'b1 || b_pc_out !== 32'h78) begin errors++; $display("FAIL rst_squash got v=%h pc=%h exp 1/78", b_out_valid, b_pc_out); end
    endtask

    task automatic test_illegal_x0();
        insn = 32'hFFFFFFFF; pc_in = 32'h80; in_valid = 1'b1;
        tick();
        checks++; if (illegal !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_flag got ill=%h v=%h exp 1/1", illegal, out_valid); end
        checks++; if ({reg_write, mem_read, mem_write, branch, jump} !== 5'b0) begin errors++; $display("FAIL ill_ctrl got %b exp 0", {reg_write, mem_read, mem_write, branch, jump}); end
        insn = 32'h00500013; pc_in = 32'h84;
        tick();
        checks++; if (reg_write !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL x0_rw got rw=%h ill=%h exp 0/0", reg_write, illegal); end
        checks++; if (imm !== 32'd5 || alu_src !== 1'b1) begin errors++; $display("FAIL x0_imm got imm=%h as=%h exp 5/1", imm, alu_src); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL idle_bubble got v=%h ill=%h exp 0/0", out_valid, illegal); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        insn = 32'h0; pc_in = 32'h0;
        test_reset();
        test_op_imm();
        test_branch_load();
        test_store_lui();
        test_jump_squash();
        test_stall_flush();
        test_long_squash();
        test_illegal_x0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
